// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - operand load, ALU control and result/flag signals of the execute slice
interface alu_result_stage_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din_a;
    logic             ld_a;
    logic [WIDTH-1:0] din_b;
    logic             ld_b;
    logic [2:0]       alucontrol;
    logic             ld_carry;
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] acc_b;
    logic [WIDTH-1:0] aluresult;
    logic [WIDTH-1:0] aluout;
    logic             cout;
    logic             carry;
    logic             zero;

    modport master (
        output din_a, ld_a, din_b, ld_b, alucontrol, ld_carry,
        input  acc_a, acc_b, aluresult, aluout, cout, carry, zero
    );

    modport slave (
        input  din_a, ld_a, din_b, ld_b, alucontrol, ld_carry,
        output acc_a, acc_b, aluresult, aluout, cout, carry, zero
    );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - operand registers, combinational ALU, result register and carry flag
module alu_result_stage #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    alu_result_stage_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_INC = 3'b110,
        OP_DEC = 3'b111
    } alu_op_t;

    logic [WIDTH-1:0] acc_a_q;
    logic [WIDTH-1:0] acc_b_q;
    logic [WIDTH-1:0] aluout_q;
    logic             carry_q;
    logic [WIDTH-1:0] result;
    logic             flag;
    logic [WIDTH:0]   wide;

    // Arithmetic ops run one bit wider so the top bit is the carry or borrow.
    always_comb begin
        result = '0;
        flag   = 1'b0;
        wide   = '0;
        case (alu_op_t'(bus.alucontrol))
            OP_AND: result = acc_a_q & acc_b_q;
            OP_OR:  result = acc_a_q | acc_b_q;
            OP_ADD: begin
                wide   = {1'b0, acc_a_q} + {1'b0, acc_b_q};
                result = wide[WIDTH-1:0];
                flag   = wide[WIDTH];
            end
            OP_SUB: begin
                wide   = {1'b0, acc_a_q} - {1'b0, acc_b_q};
                result = wide[WIDTH-1:0];
                flag   = wide[WIDTH];
            end
            OP_XOR: result = acc_a_q ^ acc_b_q;
            OP_NOT: result = ~acc_a_q;
            OP_INC: begin
                wide   = {1'b0, acc_a_q} + (WIDTH+1)'(1);
                result = wide[WIDTH-1:0];
                flag   = wide[WIDTH];
            end
            OP_DEC: begin
                wide   = {1'b0, acc_a_q} - (WIDTH+1)'(1);
                result = wide[WIDTH-1:0];
                flag   = wide[WIDTH];
            end
            default: begin
                result = '0;
                flag   = 1'b0;
            end
        endcase
    end

    // Carry samples the flag of the operands held before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            aluout_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            if (bus.ld_a)     acc_a_q <= bus.din_a;
            if (bus.ld_b)     acc_b_q <= bus.din_b;
            if (bus.ld_carry) carry_q <= flag;
            aluout_q <= result;
        end
    end

    assign bus.acc_a     = acc_a_q;
    assign bus.acc_b     = acc_b_q;
    assign bus.aluresult = result;
    assign bus.aluout    = aluout_q;
    assign bus.cout      = flag;
    assign bus.carry     = carry_q;
    assign bus.zero      = (acc_a_q == '0);
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    alu_result_stage_if #(.WIDTH(8)) bus ();

    alu_result_stage #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.din_a = 8'h00;
        bus.ld_a = 1'b0;
        bus.din_b = 8'h00;
        bus.ld_b = 1'b0;
        bus.alucontrol = 3'b000;
        bus.ld_carry = 1'b0;
        tick();
        tick();
        check("rst_acc_a", 32'(bus.acc_a), 32'h00);
        check("rst_acc_b", 32'(bus.acc_b), 32'h00);
        check("rst_aluout", 32'(bus.aluout), 32'h00);
        check("rst_carry", 32'(bus.carry), 32'h0);
        check("rst_zero", 32'(bus.zero), 32'h1);
        reset = 1'b1;

        // ADD with carry out, then capture carry and registered result
        bus.din_a = 8'hF0; bus.din_b = 8'h20; bus.ld_a = 1'b1; bus.ld_b = 1'b1;
        bus.alucontrol = 3'b010;
        tick();
        bus.ld_a = 1'b0; bus.ld_b = 1'b0;
        check("add_result", 32'(bus.aluresult), 32'h10);
        check("add_cout", 32'(bus.cout), 32'h1);
        check("add_zero", 32'(bus.zero), 32'h0);
        bus.ld_carry = 1'b1;
        tick();
        bus.ld_carry = 1'b0;
        check("add_aluout", 32'(bus.aluout), 32'h10);
        check("add_carry", 32'(bus.carry), 32'h1);

        // asynchronous reset mid-run
        bus.din_a = 8'h5A; bus.ld_a = 1'b1;
        tick();
        bus.ld_a = 1'b0;
        check("pre_rst_acc_a", 32'(bus.acc_a), 32'h5A);
        check("pre_rst_carry", 32'(bus.carry), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_acc_a", 32'(bus.acc_a), 32'h00);
        check("async_acc_b", 32'(bus.acc_b), 32'h00);
        check("async_aluout", 32'(bus.aluout), 32'h00);
        check("async_carry", 32'(bus.carry), 32'h0);
        check("async_zero", 32'(bus.zero), 32'h1);
        bus.din_a = 8'h33; bus.ld_a = 1'b1; bus.ld_carry = 1'b1;
        tick();
        check("rst_blocks_load", 32'(bus.acc_a), 32'h00);
        check("rst_blocks_carry", 32'(bus.carry), 32'h0);
        bus.ld_a = 1'b0; bus.ld_carry = 1'b0;
        reset = 1'b1;

        // SUB with borrow, then reload while carry captures old borrow
        bus.alucontrol = 3'b011;
        bus.din_a = 8'h05; bus.din_b = 8'h07; bus.ld_a = 1'b1; bus.ld_b = 1'b1;
        tick();
        check("sub_borrow_result", 32'(bus.aluresult), 32'hFE);
        check("sub_borrow_cout", 32'(bus.cout), 32'h1);
        bus.din_a = 8'h07; bus.din_b = 8'h05; bus.ld_carry = 1'b1;
        tick();
        bus.ld_a = 1'b0; bus.ld_b = 1'b0; bus.ld_carry = 1'b0;
        check("sub_result", 32'(bus.aluresult), 32'h02);
        check("sub_cout", 32'(bus.cout), 32'h0);
        check("sub_old_carry", 32'(bus.carry), 32'h1);
        check("sub_aluout_latency", 32'(bus.aluout), 32'hFE);

        // INC wrap, feed back zero, DEC wrap
        bus.alucontrol = 3'b110;
        bus.din_a = 8'hFF; bus.ld_a = 1'b1;
        tick();
        bus.ld_a = 1'b0;
        check("inc_result", 32'(bus.aluresult), 32'h00);
        check("inc_cout", 32'(bus.cout), 32'h1);
        check("inc_zero_ff", 32'(bus.zero), 32'h0);
        bus.din_a = 8'h00; bus.ld_a = 1'b1;
        tick();
        bus.ld_a = 1'b0;
        check("fb_zero", 32'(bus.zero), 32'h1);
        bus.alucontrol = 3'b111;
        #1;
        check("dec_result", 32'(bus.aluresult), 32'hFF);
        check("dec_cout", 32'(bus.cout), 32'h1);
        check("dec_zero_acc_only", 32'(bus.zero), 32'h1);
        bus.alucontrol = 3'b000; bus.ld_carry = 1'b1;
        tick();
        bus.ld_carry = 1'b0;
        check("and_clears_carry", 32'(bus.carry), 32'h0);

        // logic ops
        bus.din_a = 8'hCC; bus.din_b = 8'hAA; bus.ld_a = 1'b1; bus.ld_b = 1'b1;
        tick();
        bus.ld_a = 1'b0; bus.ld_b = 1'b0;
        bus.alucontrol = 3'b000; #1;
        check("and_result", 32'(bus.aluresult), 32'h88);
        check("and_cout", 32'(bus.cout), 32'h0);
        bus.alucontrol = 3'b001; #1;
        check("or_result", 32'(bus.aluresult), 32'hEE);
        check("or_cout", 32'(bus.cout), 32'h0);
        bus.alucontrol = 3'b100; #1;
        check("xor_result", 32'(bus.aluresult), 32'h66);
        check("xor_cout", 32'(bus.cout), 32'h0);
        bus.alucontrol = 3'b101; #1;
        check("not_result", 32'(bus.aluresult), 32'h33);
        check("not_cout", 32'(bus.cout), 32'h0);
        tick();
        check("not_aluout", 32'(bus.aluout), 32'h33);

        // CC + AA = 0x176: set carry, then hold everything for five cycles
        bus.alucontrol = 3'b010; bus.ld_carry = 1'b1;
        tick();
        bus.ld_carry = 1'b0;
        check("hold_setup_carry", 32'(bus.carry), 32'h1);
        check("hold_setup_aluout", 32'(bus.aluout), 32'h76);
        for (int i = 0; i < 5; i++) begin
            bus.din_a = (i % 2 == 0) ? 8'h11 : 8'hEE;
            bus.din_b = (i % 2 == 0) ? 8'h0F : 8'hF0;
            tick();
            check("hold_acc_a", 32'(bus.acc_a), 32'hCC);
            check("hold_acc_b", 32'(bus.acc_b), 32'hAA);
            check("hold_carry", 32'(bus.carry), 32'h1);
            check("hold_aluout", 32'(bus.aluout), 32'h76);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Operand-and-execute slice of the 8-bit processor datapath.
- Contains two load-enabled operand registers (accumulator AB and operand BB), a combinational ALU, a free-running result register and a load-enabled carry flag.
- Operand multiplexing is done upstream; the registered result feeds back to the AB source mux.

Parameters:
WIDTH, 8, data path width for operands, result and ALU.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
din_a  input  WIDTH  next value for operand register AB.
ld_a  input  1  load enable for AB.
din_b  input  WIDTH  next value for operand register BB.
ld_b  input  1  load enable for BB.
alucontrol  input  3  ALU operation select.
ld_carry  input  1  load enable for carry flag.
acc_a  output  WIDTH  current AB register value.
acc_b  output  WIDTH  current BB register value.
aluresult  output  WIDTH  combinational ALU result of acc_a, acc_b.
aluout  output  WIDTH  aluresult registered one cycle.
cout  output  1  combinational ALU carry/borrow.
carry  output  1  registered carry flag.
zero  output  1  combinational, 1 when acc_a == 0.

Behaviour:
Reset:
- When reset is low, clear acc_a, acc_b, aluout and carry to 0 immediately, independent of clk.
- All registers hold 0 while reset stays low.
- Release is synchronous to the next rising edge; no loads occur on the edge where reset is low.

Operand registers:
- On a rising edge, acc_a <= din_a when ld_a = 1, otherwise it holds.
- acc_b follows the same rule with din_b / ld_b.
- ld_a and ld_b are independent and may be asserted together.

ALU:
- Purely combinational on acc_a (A) and acc_b (B); all results are truncated modulo 2^WIDTH.
- Operations by alucontrol:
  - 000 AND: A & B, cout 0.
  - 001 OR: A | B, cout 0.
  - 010 ADD: A + B, cout = bit WIDTH of the (WIDTH+1)-bit sum.
  - 011 SUB: A - B, cout = 1 when A < B unsigned (borrow).
  - 100 XOR: A ^ B, cout 0.
  - 101 NOT: ~A, cout 0.
  - 110 INC: A + 1, cout = 1 when A = all-ones (result wraps to 0).
  - 111 DEC: A - 1, cout = 1 when A = 0 (result wraps to all-ones).
- No X on aluresult or cout for any control value.

Result register:
- aluout <= aluresult on every rising edge; no enable.
- Latency: operands loaded at edge N produce aluresult during cycle N and appear on aluout after edge N+1.

Carry flag:
- On a rising edge, carry <= cout when ld_carry = 1, otherwise it holds.
- The sampled cout is computed from the acc_a / acc_b values present before that edge, not from the values being loaded.

Zero flag:
- Combinational on acc_a only; it does not depend on aluresult.

Simultaneous events:
- Loading AB while ld_carry is asserted: carry captures the flag from the old operands.
- Asynchronous reset overrides every enable.

Test Plan:
1. Reset low mid-run with acc_a = 0x5A and carry = 1 -> acc_a, acc_b, aluout and carry read 0 immediately, with no clock edge; zero = 1.
2. Load A = 0xF0, B = 0x20, alucontrol = 010, then assert ld_carry for one edge -> aluresult = 0x10 and cout = 1 combinationally; aluout = 0x10 one edge later; carry = 1.
3. SUB with A = 0x05, B = 0x07 -> aluresult = 0xFE, cout = 1; with A = 0x07, B = 0x05 -> aluresult = 0x02, cout = 0.
4. INC with A = 0xFF -> aluresult = 0x00, cout = 1; then load that result into AB via din_a -> zero = 1. DEC with A = 0x00 -> aluresult = 0xFF, cout = 1.
5. Logic ops with A = 0xCC, B = 0xAA -> AND 0x88, OR 0xEE, XOR 0x66, NOT 0x33, cout 0 in all four cases.
6. Hold check: ld_a = ld_b = ld_carry = 0 for 5 cycles while din_a and din_b toggle -> acc_a, acc_b and carry stay unchanged and aluout stays constant.
